// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv
//  Purpose  : Execute-stage multiply/divide unit with architectural HI/LO.
//             Single-cycle MULT/MULTU/MTHI/MTLO, combinational MFHI/MFLO,
//             and a 32-step restoring divider that stalls the front end.
//  Revision : 1.0  initial release
// ============================================================================
module ex_muldiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] input_inst,
  input  logic [31:0] input_rsvalue,
  input  logic [31:0] input_rtvalue,
  input  logic        input_flush,
  output logic        output_stall,
  output logic [31:0] output_hilo_value,
  output logic [31:0] output_hi,
  output logic [31:0] output_lo,
  output logic        output_busy
);

  localparam logic [5:0] C_FN_MFHI  = 6'h10;
  localparam logic [5:0] C_FN_MTHI  = 6'h11;
  localparam logic [5:0] C_FN_MFLO  = 6'h12;
  localparam logic [5:0] C_FN_MTLO  = 6'h13;
  localparam logic [5:0] C_FN_MULT  = 6'h18;
  localparam logic [5:0] C_FN_MULTU = 6'h19;
  localparam logic [5:0] C_FN_DIV   = 6'h1A;
  localparam logic [5:0] C_FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in.
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic [4:0]  r_count;
  // Sign corrections resolved at issue; a zero divisor never negates the
  // quotient so LO ends up all ones and HI ends up equal to raw rs.
  logic        r_neg_quot;
  logic        r_neg_rem;

  logic        w_rtype;
  logic [5:0]  w_funct;
  logic        w_op_mfhi, w_op_mthi, w_op_mflo, w_op_mtlo;
  logic        w_op_mult, w_op_multu, w_op_div, w_op_divu, w_op_div_any;
  logic [31:0] w_rs_abs;
  logic [31:0] w_rt_abs;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [32:0] w_rem_shift;
  logic [32:0] w_rem_diff;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [31:0] w_quot_next;
  logic [31:0] w_quot_final;
  logic [31:0] w_rem_final;
  logic        w_unused;

  assign w_rtype      = (input_inst[31:26] == 6'd0);
  assign w_funct      = input_inst[5:0];
  assign w_op_mfhi    = w_rtype && (w_funct == C_FN_MFHI);
  assign w_op_mthi    = w_rtype && (w_funct == C_FN_MTHI);
  assign w_op_mflo    = w_rtype && (w_funct == C_FN_MFLO);
  assign w_op_mtlo    = w_rtype && (w_funct == C_FN_MTLO);
  assign w_op_mult    = w_rtype && (w_funct == C_FN_MULT);
  assign w_op_multu   = w_rtype && (w_funct == C_FN_MULTU);
  assign w_op_div     = w_rtype && (w_funct == C_FN_DIV);
  assign w_op_divu    = w_rtype && (w_funct == C_FN_DIVU);
  assign w_op_div_any = w_op_div || w_op_divu;

  assign w_rs_abs = (w_op_div && input_rsvalue[31]) ? (~input_rsvalue + 32'd1) : input_rsvalue;
  assign w_rt_abs = (w_op_div && input_rtvalue[31]) ? (~input_rtvalue + 32'd1) : input_rtvalue;

  assign w_prod_s = {{32{input_rsvalue[31]}}, input_rsvalue} * {{32{input_rtvalue[31]}}, input_rtvalue};
  assign w_prod_u = {32'd0, input_rsvalue} * {32'd0, input_rtvalue};

  // One restoring step: shift in the next dividend bit, trial-subtract.
  assign w_rem_shift  = {r_rem, r_quot[31]};
  assign w_rem_diff   = w_rem_shift - {1'b0, r_divisor};
  assign w_qbit       = ~w_rem_diff[32];
  assign w_rem_next   = w_qbit ? w_rem_diff[31:0] : w_rem_shift[31:0];
  assign w_quot_next  = {r_quot[30:0], w_qbit};
  assign w_quot_final = r_neg_quot ? (~w_quot_next + 32'd1) : w_quot_next;
  assign w_rem_final  = r_neg_rem  ? (~w_rem_next + 32'd1)  : w_rem_next;

  assign w_unused = ^input_inst[25:6];

  // Stall covers the issue cycle and every BUSY cycle; a flush releases it at once.
  always_comb begin
    output_stall = 1'b0;
    if (!input_flush) begin
      if (r_state == S_IDLE && w_op_div_any) output_stall = 1'b1;
      if (r_state == S_BUSY)                 output_stall = 1'b1;
    end
  end

  // MFHI/MFLO read the architectural registers directly; no forwarding.
  always_comb begin
    output_hilo_value = 32'd0;
    if (w_op_mfhi) output_hilo_value = r_hi;
    if (w_op_mflo) output_hilo_value = r_lo;
  end

  assign output_hi   = r_hi;
  assign output_lo   = r_lo;
  assign output_busy = r_busy;

  // HI/LO updates plus the IDLE -> BUSY -> DONE divide sequencer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_quot     <= 32'd0;
      r_rem      <= 32'd0;
      r_divisor  <= 32'd0;
      r_count    <= 5'd0;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!input_flush) begin
            if (w_op_div_any) begin
              r_quot     <= w_rs_abs;
              r_rem      <= 32'd0;
              r_divisor  <= w_rt_abs;
              r_count    <= 5'd0;
              r_neg_quot <= w_op_div && (input_rsvalue[31] ^ input_rtvalue[31])
                            && (input_rtvalue != 32'd0);
              r_neg_rem  <= w_op_div && input_rsvalue[31];
              r_state    <= S_BUSY;
              r_busy     <= 1'b1;
            end else if (w_op_mult) begin
              r_hi <= w_prod_s[63:32];
              r_lo <= w_prod_s[31:0];
            end else if (w_op_multu) begin
              r_hi <= w_prod_u[63:32];
              r_lo <= w_prod_u[31:0];
            end else if (w_op_mthi) begin
              r_hi <= input_rsvalue;
            end else if (w_op_mtlo) begin
              r_lo <= input_rsvalue;
            end
          end
        end
        S_BUSY: begin
          if (input_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_quot  <= w_quot_next;
            r_rem   <= w_rem_next;
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) begin
              r_lo    <= w_quot_final;
              r_hi    <= w_rem_final;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_muldiv
//  Purpose  : Self-checking scoreboard bench for ex_muldiv.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;

  localparam logic [5:0] C_FN_NOP   = 6'h00;
  localparam logic [5:0] C_FN_MFHI  = 6'h10;
  localparam logic [5:0] C_FN_MTHI  = 6'h11;
  localparam logic [5:0] C_FN_MFLO  = 6'h12;
  localparam logic [5:0] C_FN_MTLO  = 6'h13;
  localparam logic [5:0] C_FN_MULT  = 6'h18;
  localparam logic [5:0] C_FN_MULTU = 6'h19;
  localparam logic [5:0] C_FN_DIV   = 6'h1A;
  localparam logic [5:0] C_FN_DIVU  = 6'h1B;

  logic        clock;
  logic        reset;
  logic [31:0] input_inst;
  logic [31:0] input_rsvalue;
  logic [31:0] input_rtvalue;
  logic        input_flush;
  logic        output_stall;
  logic [31:0] output_hilo_value;
  logic [31:0] output_hi;
  logic [31:0] output_lo;
  logic        output_busy;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_checks;
  int          n_pass;
  time         t_issue;

  ex_muldiv dut (
    .clock             (clock),
    .reset             (reset),
    .input_inst        (input_inst),
    .input_rsvalue     (input_rsvalue),
    .input_rtvalue     (input_rtvalue),
    .input_flush       (input_flush),
    .output_stall      (output_stall),
    .output_hilo_value (output_hilo_value),
    .output_hi         (output_hi),
    .output_lo         (output_lo),
    .output_busy       (output_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    input_inst    = {26'd0, fn};
    input_rsvalue = rs;
    input_rtvalue = rt;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.tag = tag; e.hi = hi; e.lo = lo;
    exp_q.push_back(e);
    m_hi = hi;
    m_lo = lo;
  endtask

  task automatic pop_check;
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_hi"}, output_hi, e.hi);
      check({e.tag, "_lo"}, output_lo, e.lo);
    end
  endtask

  function automatic logic [63:0] model_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (sgn) return 64'(sa * sb);
    return 64'(ua * ub);
  endfunction

  task automatic model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (sgn) begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  // Single-cycle op: stall must stay low, result visible next cycle.
  task automatic run_mult(input string tag, input bit sgn, input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] p;
    p = model_mult(sgn, rs, rt);
    drive(sgn ? C_FN_MULT : C_FN_MULTU, rs, rt);
    push_exp(tag, p[63:32], p[31:0]);
    @(negedge clock);
    check({tag, "_stall"}, {31'd0, output_stall}, 32'd0);
    tick;
    drive(C_FN_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    check({tag, "_mflo"}, output_hilo_value, m_lo);
    pop_check();
    tick;
  endtask

  // abort_c < 0: run to completion; otherwise flush (or reset) in that cycle.
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] rs, input logic [31:0] rt,
                         input int abort_c, input bit use_reset);
    logic [31:0] q, r;
    int          stalls;
    bit          finished;
    model_div(sgn, rs, rt, q, r);
    drive(sgn ? C_FN_DIV : C_FN_DIVU, rs, rt);
    t_issue = $time;
    if (abort_c < 0)   push_exp(tag, r, q);
    else if (use_reset) push_exp(tag, 32'd0, 32'd0);
    else               push_exp(tag, m_hi, m_lo);
    stalls   = 0;
    finished = 0;
    for (int c = 0; c < 40 && !finished; c++) begin
      if (c == abort_c) begin
        if (use_reset) reset = 1'b1;
        else input_flush = 1'b1;
      end
      @(negedge clock);
      if (c == 1) check({tag, "_busy"}, {31'd0, output_busy}, 32'd1);
      if (c == abort_c) begin
        if (!use_reset) check({tag, "_flush_stall"}, {31'd0, output_stall}, 32'd0);
        finished = 1;
      end else if (output_stall) begin
        stalls++;
      end else begin
        finished = 1;
        check({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
        check({tag, "_done_busy"}, {31'd0, output_busy}, 32'd0);
        pop_check();
      end
      tick;
    end
    if (!finished) check({tag, "_timeout"}, 32'd0, 32'd1);
    if (abort_c >= 0) begin
      reset       = 1'b0;
      input_flush = 1'b0;
      drive(C_FN_NOP, 32'd0, 32'd0);
      @(negedge clock);
      check({tag, "_abort_busy"}, {31'd0, output_busy}, 32'd0);
      check({tag, "_abort_stall"}, {31'd0, output_stall}, 32'd0);
      pop_check();
      tick;
    end
  endtask

  initial begin
    time t_a;
    n_checks    = 0;
    n_pass      = 0;
    m_hi        = 32'd0;
    m_lo        = 32'd0;
    reset       = 1'b1;
    input_flush = 1'b0;
    drive(C_FN_NOP, 32'd0, 32'd0);
    tick;
    tick;
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_hi", output_hi, 32'd0);
    check("rst_lo", output_lo, 32'd0);
    check("rst_stall", {31'd0, output_stall}, 32'd0);
    check("rst_busy", {31'd0, output_busy}, 32'd0);
    tick;

    // MTHI then MFLO / MFHI
    drive(C_FN_MTHI, 32'h1234_5678, 32'd0);
    push_exp("mthi", 32'h1234_5678, m_lo);
    tick;
    drive(C_FN_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    check("mflo_val", output_hilo_value, 32'd0);
    pop_check();
    tick;
    drive(C_FN_MFHI, 32'd0, 32'd0);
    @(negedge clock);
    check("mfhi_val", output_hilo_value, 32'h1234_5678);
    tick;

    // Multiplies
    run_mult("mult", 1'b1, 32'hFFFF_FFFF, 32'd2);
    check("mult_hi_const", m_hi, 32'hFFFF_FFFF);
    run_mult("multu", 1'b0, 32'hFFFF_FFFF, 32'd2);
    run_mult("mult_mix", 1'b1, 32'h8000_0001, 32'h7FFF_FFFF);

    // MTLO and MULT while flushed in IDLE: no architectural effect
    input_flush = 1'b1;
    drive(C_FN_MTLO, 32'hDEAD_BEEF, 32'd0);
    tick;
    drive(C_FN_MULT, 32'd3, 32'd5);
    tick;
    input_flush = 1'b0;
    drive(C_FN_NOP, 32'd0, 32'd0);
    push_exp("idle_flush", m_hi, m_lo);
    @(negedge clock);
    pop_check();
    tick;
    drive(C_FN_MTLO, 32'hCAFE_F00D, 32'd0);
    push_exp("mtlo", m_hi, 32'hCAFE_F00D);
    tick;
    drive(C_FN_NOP, 32'd0, 32'd0);
    @(negedge clock);
    pop_check();
    tick;

    // Divides
    run_div("div_neg", 1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    drive(C_FN_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    check("div_neg_mflo", output_hilo_value, 32'hFFFF_FFFD);
    tick;
    run_div("divu_zero", 1'b0, 32'd100, 32'd0, -1, 1'b0);
    run_div("div_zero_neg", 1'b1, 32'hFFFF_FFF9, 32'd0, -1, 1'b0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    run_div("div_mix", 1'b1, 32'd1000, 32'hFFFF_FFF9, -1, 1'b0);
    run_div("divu_flush", 1'b0, 32'd100, 32'd7, 10, 1'b0);
    run_div("divu_reset", 1'b0, 32'd100, 32'd7, 10, 1'b1);

    // Back-to-back, no bubble between
    run_div("b2b_1", 1'b0, 32'd100, 32'd7, -1, 1'b0);
    t_a = t_issue;
    run_div("b2b_2", 1'b0, 32'd9, 32'd3, -1, 1'b0);
    check("b2b_spacing", 32'((t_issue - t_a) / 10), 32'd34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
